// File: rtl/backprop_w1_scheduler_pkg.sv
// Shared state encodings and default latencies for the layer-1 weight-update scheduler.
// Pure definitions: no logic, no latency, no flow control.
package backprop_w1_scheduler_pkg;

  localparam int DEF_RD_LAT = 1;
  localparam int DEF_DP_LAT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bp_tag_pipe.sv
// Fixed-depth valid+tag shift register that mirrors the datapath pipeline; DEPTH-cycle latency.
// Never stalls (the datapath cannot); flush clears all valids on the next edge.
module bp_tag_pipe #(
  parameter int DEPTH = 10,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  output logic [W-1:0] pop_dat,
  output logic         any_vld
);

  logic [DEPTH-1:0]        vld;
  logic [DEPTH-1:0][W-1:0] dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      dat <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= push_vld;
        for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
      end
      dat[0] <= push_dat;
      for (int k = 1; k < DEPTH; k++) dat[k] <= dat[k-1];
    end
  end

  assign pop_vld = vld[DEPTH-1];
  assign pop_dat = dat[DEPTH-1];
  assign any_vld = |vld;

endmodule

// File: rtl/backprop_w1_scheduler.sv
// Walks all N_HID x N_IN weights, one read per cycle; write lands RD_LAT+DP_LAT+1 cycles after its read.
// hold pauses issue only; in-flight results always drain since the datapath cannot stall.
module backprop_w1_scheduler
  import backprop_w1_scheduler_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_HID  = 4,
  parameter int IN_AW  = 2,
  parameter int HID_AW = 2,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int DP_LAT = DEF_DP_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_in_idx,
  output logic [HID_AW-1:0] rd_hid_idx,
  input  logic [31:0]       dp_w_new,
  output logic              wr_en,
  output logic [IN_AW-1:0]  wr_in_idx,
  output logic [HID_AW-1:0] wr_hid_idx,
  output logic [31:0]       wr_data
);

  localparam int T  = RD_LAT + DP_LAT;
  localparam int TW = HID_AW + IN_AW;
  localparam logic [IN_AW-1:0]  LAST_IN  = IN_AW'(N_IN - 1);
  localparam logic [HID_AW-1:0] LAST_HID = HID_AW'(N_HID - 1);

  state_e            state, state_nxt;
  logic [IN_AW-1:0]  in_idx;
  logic [HID_AW-1:0] hid_idx;
  logic              last_issue;
  logic              pop_vld;
  logic [TW-1:0]     pop_dat;
  logic              pipe_busy;

  assign last_issue = (in_idx == LAST_IN) && (hid_idx == LAST_HID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // abort outranks start in IDLE and suppresses the read issued in the abort cycle
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      ST_IDLE:  if (start && !abort) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        rd_en = !hold && !abort;
        if (abort)                   state_nxt = ST_IDLE;
        else if (rd_en && last_issue) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (!pipe_busy) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign rd_in_idx  = in_idx;
  assign rd_hid_idx = hid_idx;

  // Counters stop on the last weight rather than wrapping; cleared outside ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_idx  <= '0;
      hid_idx <= '0;
    end else if (state != ST_ISSUE || abort) begin
      in_idx  <= '0;
      hid_idx <= '0;
    end else if (rd_en && !last_issue) begin
      if (in_idx == LAST_IN) begin
        in_idx  <= '0;
        hid_idx <= hid_idx + 1'b1;
      end else begin
        in_idx  <= in_idx + 1'b1;
      end
    end
  end

  bp_tag_pipe #(
    .DEPTH (T),
    .W     (TW)
  ) u_tag_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort),
    .push_vld (rd_en),
    .push_dat ({hid_idx, in_idx}),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .any_vld  (pipe_busy)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_data    <= '0;
      wr_in_idx  <= '0;
      wr_hid_idx <= '0;
    end else begin
      wr_en <= pop_vld && !abort;
      if (pop_vld) begin
        wr_data                   <= dp_w_new;
        {wr_hid_idx, wr_in_idx}   <= pop_dat;
      end
    end
  end

endmodule

// File: tb/tb_backprop_w1_scheduler.sv
// Directed bench: datapath model echoes the read tag as w_new, logs reads/writes/done and checks timing.
module tb_backprop_w1_scheduler;

  localparam int T      = 10;
  localparam int WR_LAT = T + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, hold;
  logic        busy, done, rd_en, wr_en;
  logic [1:0]  rd_in_idx, rd_hid_idx, wr_in_idx, wr_hid_idx;
  logic [31:0] dp_w_new, wr_data;

  always #5 clk = ~clk;

  backprop_w1_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_in_idx  (rd_in_idx),
    .rd_hid_idx (rd_hid_idx),
    .dp_w_new   (dp_w_new),
    .wr_en      (wr_en),
    .wr_in_idx  (wr_in_idx),
    .wr_hid_idx (wr_hid_idx),
    .wr_data    (wr_data)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  h;
    logic [1:0]  i;
    logic [31:0] d;
  } ev_t;

  typedef struct {
    bit         v;
    logic [1:0] h;
    logic [1:0] i;
  } rd_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  rd_t dp_m[T+1];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [31:0] enc(logic [1:0] h, logic [1:0] i);
    return {16'h3F80, 8'h00, 2'b00, h, 2'b00, i};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observe mid-cycle; the datapath model returns read-tag data T cycles after each read.
  always @(negedge clk) begin
    if (rd_en) rd_q.push_back('{cyc, rd_hid_idx, rd_in_idx, 32'h0});
    if (wr_en) wr_q.push_back('{cyc, wr_hid_idx, wr_in_idx, wr_data});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int j = T; j > 0; j--) dp_m[j] = dp_m[j-1];
    dp_m[0] = '{rd_en, rd_hid_idx, rd_in_idx};
    dp_w_new = dp_m[T].v ? enc(dp_m[T].h, dp_m[T].i) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // first: cycle of first read; gap_at/gap_len: reads from index gap_at onward shift by gap_len
  task automatic verify_sweep(input string nm, input int first, input int gap_at, input int gap_len);
    int         ec;
    logic [1:0] eh, ei;
    ec = 0;
    chk({nm, "_rd_cnt"}, rd_q.size(), 16);
    chk({nm, "_wr_cnt"}, wr_q.size(), 16);
    for (int k = 0; k < 16; k++) begin
      eh = 2'(k / 4);
      ei = 2'(k % 4);
      ec = first + k + ((k >= gap_at) ? gap_len : 0);
      if (k < rd_q.size()) begin
        chk({nm, "_rd_idx"}, {rd_q[k].h, rd_q[k].i}, {eh, ei});
        chk({nm, "_rd_cyc"}, rd_q[k].cyc, ec);
      end
      if (k < wr_q.size()) begin
        chk({nm, "_wr_idx"}, {wr_q[k].h, wr_q[k].i}, {eh, ei});
        chk({nm, "_wr_cyc"}, wr_q[k].cyc, ec + WR_LAT);
        chk({nm, "_wr_dat"}, wr_q[k].d, enc(eh, ei));
      end
    end
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_done_cyc"}, done_cyc, ec + WR_LAT + 1);
  endtask

  int s;
  int rst_cyc;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    hold = 1'b0;
    dp_w_new = 32'hDEAD_BEEF;
    for (int j = 0; j <= T; j++) dp_m[j] = '{1'b0, 2'd0, 2'd0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, done, rd_en, wr_en}, 4'b0);
    chk("rst_idx", {rd_hid_idx, rd_in_idx, wr_hid_idx, wr_in_idx}, 8'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Plain sweep
    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("plain_busy", busy, 1'b1);
    repeat (40) tick();
    verify_sweep("plain", s + 1, 16, 0);
    chk("plain_idle", busy, 1'b0);

    // hold for 3 cycles after the 5th read
    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    repeat (40) tick();
    verify_sweep("hold", s + 1, 5, 3);

    // start and abort together in IDLE: abort wins
    clear_logs();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    repeat (3) tick();
    chk("sa_rd_cnt", rd_q.size(), 0);

    // abort on the 8th ISSUE cycle
    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    repeat (25) tick();
    chk("abort_rd_cnt", rd_q.size(), 7);
    chk("abort_wr_cnt", wr_q.size(), 0);
    chk("abort_done_cnt", done_cnt, 0);

    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    verify_sweep("post_abort", s + 1, 16, 0);

    // start re-pulsed in ISSUE and in DRAIN
    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    verify_sweep("restart", s + 1, 16, 0);

    // reset in DRAIN
    clear_logs();
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_cyc = cyc;
    reset_n = 1'b0;
    #1;
    chk("drst_outs", {busy, done, rd_en, wr_en}, 4'b0);
    chk("drst_wr", {wr_hid_idx, wr_in_idx, wr_data}, 36'h0);
    chk("drst_wr_cnt", wr_q.size(), rst_cyc - (s + 1 + WR_LAT));
    repeat (2) tick();
    reset_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    chk("drst_stray_wr", wr_q.size(), 0);
    chk("drst_stray_rd", rd_q.size(), 0);
    chk("drst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
